// File: rtl/muldiv_unit_pkg.sv
// Shared op codes and FSM state encoding for the multiply/divide engine.
package muldiv_unit_pkg;

  localparam logic [1:0] MD_MULU = 2'b00;
  localparam logic [1:0] MD_MUL  = 2'b01;
  localparam logic [1:0] MD_DIVU = 2'b10;
  localparam logic [1:0] MD_DIV  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Bit 0 of the op code marks the signed variants of both mul and div.
  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor if it fits.
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor, so the WIDTH+1-bit difference sign is exact.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine with start/done handshake and flush.
//   state   | meaning
//   IDLE    | waiting for start
//   MUL     | product moving through the multiply pipeline
//   DIV     | one restoring quotient bit per cycle
//   FIX     | sign correction / divide-by-zero result, result registered
//   DONE    | done pulse, new start accepted
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int MUL_STAGES    = 3,
  parameter int DIV_ZERO_FAST = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int CNT_W_DIV = $clog2(WIDTH) + 1;
  localparam int CNT_W_MUL = $clog2(MUL_STAGES) + 1;
  localparam int CNT_W     = (CNT_W_DIV > CNT_W_MUL) ? CNT_W_DIV : CNT_W_MUL;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_STAGES - 1);

  state_t             state_q, state_d;
  logic               accept;
  logic               in_is_div, in_b_zero, in_div_signed;
  logic [WIDTH-1:0]   a_q, b_q, a_raw_q, rem_q, quo_q;
  logic               signed_q, q_neg_q, r_neg_q, dbz_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic [2*WIDTH-1:0] a_ext, b_ext, product, mul_out;
  logic [2*WIDTH-1:0] result_q;
  logic               dbz_out_q;

  assign in_is_div     = op_is_div(op);
  assign in_b_zero     = (src_b == '0);
  assign in_div_signed = (op == MD_DIV);
  assign accept        = start && !flush && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  assign busy        = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign done        = (state_q == ST_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_out_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (!in_is_div)                             state_d = ST_MUL;
          else if (in_b_zero && (DIV_ZERO_FAST != 0)) state_d = ST_FIX;
          else                                        state_d = ST_DIV;
        end
      end
      ST_MUL:  if (cnt_q == '0) state_d = ST_DONE;
      ST_DIV:  if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_q),
    .dividend_bit (quo_q[WIDTH-1]),
    .divisor      (b_q),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  // Full-width two's-complement product from the latched operands.
  always_comb begin
    a_ext   = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext   = signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product = a_ext * b_ext;
  end

  // The result register is the last of MUL_STAGES product stages.
  if (MUL_STAGES == 1) begin : g_mul_direct
    assign mul_out = product;
  end else begin : g_mul_pipe
    logic [2*WIDTH-1:0] pipe [MUL_STAGES-1];

    // Free-running delay line; only the tap at the right cycle is used.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < MUL_STAGES - 1; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= product;
        for (int i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign mul_out = pipe[MUL_STAGES-2];
  end

  // Operand capture, iteration, sign fix-up and result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      signed_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      dbz_out_q <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        a_q      <= (in_div_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        b_q      <= (in_div_signed && src_b[WIDTH-1]) ? -src_b : src_b;
        quo_q    <= (in_div_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        rem_q    <= '0;
        a_raw_q  <= src_a;
        signed_q <= op[0];
        q_neg_q  <= in_div_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        r_neg_q  <= in_div_signed && src_a[WIDTH-1];
        dbz_q    <= in_is_div && in_b_zero;
        cnt_q    <= in_is_div ? DIV_LOAD : MUL_LOAD;
      end else begin
        case (state_q)
          ST_MUL: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else begin
              result_q  <= mul_out;
              dbz_out_q <= 1'b0;
            end
          end
          ST_DIV: begin
            rem_q <= rem_next;
            quo_q <= {quo_q[WIDTH-2:0], q_bit};
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
          end
          ST_FIX: begin
            dbz_out_q <= dbz_q;
            if (dbz_q) result_q <= {a_raw_q, {WIDTH{1'b1}}};
            else       result_q <= {(r_neg_q ? -rem_q : rem_q), (q_neg_q ? -quo_q : quo_q)};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed test of muldiv_unit: mul/div latency, signs, divide by zero,
// back-to-back start, ignored start while busy, flush and mid-op reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int pulses;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  muldiv_unit #(.WIDTH(32), .MUL_STAGES(3), .DIV_ZERO_FAST(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Current cycle becomes cycle 0; returns in cycle 1 with operands scrambled.
  task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    step();
    start = 1'b0;
    op    = OP_MULU;
    src_a = 32'hDEAD_BEEF;
    src_b = 32'h0000_0000;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = OP_MULU;
    src_a = '0;
    src_b = '0;
    flush = 1'b0;
    step();
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    step();

    // MULU max * max
    go(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulu_c1_busy", 64'(busy), 64'd1);
    check("mulu_c1_done", 64'(done), 64'd0);
    step();
    check("mulu_c2_busy", 64'(busy), 64'd1);
    step();
    check("mulu_c3_busy", 64'(busy), 64'd1);
    check("mulu_c3_done", 64'(done), 64'd0);
    step();
    check("mulu_c4_done", 64'(done), 64'd1);
    check("mulu_c4_busy", 64'(busy), 64'd0);
    check("mulu_result", result, 64'hFFFF_FFFE_0000_0001);
    check("mulu_dbz", 64'(div_by_zero), 64'd0);
    step();
    check("mulu_c5_done", 64'(done), 64'd0);
    check("mulu_hold", result, 64'hFFFF_FFFE_0000_0001);

    // MUL -1 * 7
    step();
    go(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0007);
    repeat (3) step();
    check("mul_c4_done", 64'(done), 64'd1);
    check("mul_result", result, 64'hFFFF_FFFF_FFFF_FFF9);

    // DIV -7 / 2
    step();
    go(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    repeat (32) step();
    check("div_c33_done", 64'(done), 64'd0);
    check("div_c33_busy", 64'(busy), 64'd1);
    step();
    check("div_c34_done", 64'(done), 64'd1);
    check("div_c34_busy", 64'(busy), 64'd0);
    check("div_result", result, 64'hFFFF_FFFF_FFFF_FFFD);

    // Back-to-back: DIV most-negative / -1 started in the done cycle
    go(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("b2b_c1_busy", 64'(busy), 64'd1);
    check("b2b_c1_done", 64'(done), 64'd0);
    repeat (4) step();
    op    = OP_MULU;
    src_a = 32'd3;
    src_b = 32'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign_start_busy", 64'(busy), 64'd1);
    repeat (3) step();
    check("ign_start_no_done", 64'(done), 64'd0);
    repeat (25) step();
    check("ovf_c34_done", 64'(done), 64'd1);
    check("ovf_result", result, 64'h0000_0000_8000_0000);

    // DIVU by zero, fast path
    step();
    go(OP_DIVU, 32'h1234_5678, 32'h0000_0000);
    check("dbz_c1_busy", 64'(busy), 64'd1);
    check("dbz_c1_done", 64'(done), 64'd0);
    step();
    check("dbz_c2_done", 64'(done), 64'd1);
    check("dbz_result", result, 64'h1234_5678_FFFF_FFFF);
    check("dbz_flag", 64'(div_by_zero), 64'd1);
    step();
    check("dbz_c3_done", 64'(done), 64'd0);
    check("dbz_flag_hold", 64'(div_by_zero), 64'd1);

    // DIVU 100 / 7
    step();
    go(OP_DIVU, 32'd100, 32'd7);
    repeat (33) step();
    check("divu_c34_done", 64'(done), 64'd1);
    check("divu_result", result, 64'h0000_0002_0000_000E);
    check("divu_dbz", 64'(div_by_zero), 64'd0);

    // Flush in cycle 10 of a DIVU
    step();
    go(OP_DIVU, 32'd100, 32'd3);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_c11_busy", 64'(busy), 64'd0);
    check("flush_c11_done", 64'(done), 64'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) pulses++;
      step();
    end
    check("flush_no_done", 64'(pulses), 64'd0);
    check("flush_result_kept", result, 64'h0000_0002_0000_000E);
    go(OP_MULU, 32'd3, 32'd5);
    repeat (3) step();
    check("after_flush_done", 64'(done), 64'd1);
    check("after_flush_result", result, 64'h0000_0000_0000_000F);

    // flush and start together: start dropped
    step();
    flush = 1'b1;
    go(OP_MUL, 32'd9, 32'd9);
    flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    repeat (3) step();
    check("flush_start_no_done", 64'(done), 64'd0);
    check("flush_start_result", result, 64'h0000_0000_0000_000F);

    // Reset mid-operation
    step();
    go(OP_MULU, 32'd2, 32'd3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", result, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
